// File: rtl/video_reg_pkg.sv
// rtl/video_reg_pkg.sv - register map, status bits and field widths for video_reg_file
package video_reg_pkg;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int COLOR_W = 12;
    localparam int SX_W    = 10;
    localparam int SY_W    = 9;
    localparam int FRAME_W = 6;

    localparam logic [ADDR_W-1:0] REG_FG_LO  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_FG_HI  = 7'h01;
    localparam logic [ADDR_W-1:0] REG_BG_LO  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_BG_HI  = 7'h03;
    localparam logic [ADDR_W-1:0] REG_SX_LO  = 7'h04;
    localparam logic [ADDR_W-1:0] REG_SX_HI  = 7'h05;
    localparam logic [ADDR_W-1:0] REG_SY_LO  = 7'h06;
    localparam logic [ADDR_W-1:0] REG_SY_HI  = 7'h07;
    localparam logic [ADDR_W-1:0] REG_FRAME  = 7'h08;
    localparam logic [ADDR_W-1:0] REG_STATUS = 7'h09;

    localparam int STATUS_PEND   = 0;
    localparam int STATUS_IRQ_EN = 1;
endpackage

// File: rtl/video_reg_if.sv
// rtl/video_reg_if.sv - strobe-based rd/wr/addr/data register bus
interface video_reg_if;
    import video_reg_pkg::*;
    logic              cs;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;

    modport master (output cs, rd, wr, addr, data, input rdata, rd_valid);
    modport slave  (input cs, rd, wr, addr, data, output rdata, rd_valid);
endinterface

// File: rtl/video_reg_file_sync_edge.sv
// rtl/video_reg_file_sync_edge.sv - 2-flop synchronizer with registered rising-edge pulse
module sync_edge (
    input  logic clk_100mhz,
    input  logic rstn_i,
    input  logic din,
    output logic pulse
);
    logic s1, s2, s2_d;

    // All flops clear to 0 so an input already high at reset release still yields an edge.
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s2_d  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s2_d  <= s2;
            pulse <= s2 & ~s2_d;
        end
    end
endmodule

// File: rtl/video_reg_file.sv
// rtl/video_reg_file.sv - double-buffered colour/scroll/frame register file committed at vsync
module video_reg_file
    import video_reg_pkg::*;
#(
    parameter bit                 VSYNC_ACTIVE_LOW = 1'b1,
    parameter logic [COLOR_W-1:0] FG_RESET         = 12'hFFF,
    parameter logic [COLOR_W-1:0] BG_RESET         = 12'h000
) (
    input  logic               clk_100mhz,
    input  logic               rstn_i,
    video_reg_if.slave         bus,
    input  logic               vsync,
    output logic [COLOR_W-1:0] fg_color,
    output logic [COLOR_W-1:0] bg_color,
    output logic [SX_W-1:0]    scroll_x,
    output logic [SY_W-1:0]    scroll_y,
    output logic [FRAME_W-1:0] frame_count,
    output logic               irq
);
    logic rd_pulse, wr_pulse, vs_pulse;
    logic rd_go, wr_go;
    logic [COLOR_W-1:0] fg_stg, bg_stg;
    logic [SX_W-1:0]    sx_stg;
    logic [SY_W-1:0]    sy_stg;
    logic               pend, irq_en;
    logic [DATA_W-1:0]  rd_mux;

    sync_edge u_rd (.clk_100mhz(clk_100mhz), .rstn_i(rstn_i), .din(bus.rd), .pulse(rd_pulse));
    sync_edge u_wr (.clk_100mhz(clk_100mhz), .rstn_i(rstn_i), .din(bus.wr), .pulse(wr_pulse));
    sync_edge u_vs (.clk_100mhz(clk_100mhz), .rstn_i(rstn_i),
                    .din(vsync ^ VSYNC_ACTIVE_LOW), .pulse(vs_pulse));

    // A write edge coinciding with a read edge suppresses the read.
    assign wr_go = wr_pulse & bus.cs;
    assign rd_go = rd_pulse & bus.cs & ~wr_pulse;

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            REG_FG_LO:  rd_mux      = fg_stg[7:0];
            REG_FG_HI:  rd_mux[3:0] = fg_stg[11:8];
            REG_BG_LO:  rd_mux      = bg_stg[7:0];
            REG_BG_HI:  rd_mux[3:0] = bg_stg[11:8];
            REG_SX_LO:  rd_mux      = sx_stg[7:0];
            REG_SX_HI:  rd_mux[1:0] = sx_stg[9:8];
            REG_SY_LO:  rd_mux      = sy_stg[7:0];
            REG_SY_HI:  rd_mux[0]   = sy_stg[8];
            REG_FRAME:  rd_mux[FRAME_W-1:0] = frame_count;
            REG_STATUS: begin
                rd_mux[STATUS_PEND]   = pend;
                rd_mux[STATUS_IRQ_EN] = irq_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            fg_stg       <= FG_RESET;
            bg_stg       <= BG_RESET;
            sx_stg       <= '0;
            sy_stg       <= '0;
            fg_color     <= FG_RESET;
            bg_color     <= BG_RESET;
            scroll_x     <= '0;
            scroll_y     <= '0;
            frame_count  <= '0;
            pend         <= 1'b0;
            irq_en       <= 1'b0;
            irq          <= 1'b0;
            bus.rdata    <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= rd_go;
            if (rd_go)
                bus.rdata <= rd_mux;

            // Commit reads the staging values as they stood before any same-cycle write.
            if (vs_pulse) begin
                fg_color    <= fg_stg;
                bg_color    <= bg_stg;
                scroll_x    <= sx_stg;
                scroll_y    <= sy_stg;
                frame_count <= frame_count + 1'b1;
            end

            if (wr_go) begin
                case (bus.addr)
                    REG_FG_LO:  fg_stg[7:0]  <= bus.data;
                    REG_FG_HI:  fg_stg[11:8] <= bus.data[3:0];
                    REG_BG_LO:  bg_stg[7:0]  <= bus.data;
                    REG_BG_HI:  bg_stg[11:8] <= bus.data[3:0];
                    REG_SX_LO:  sx_stg[7:0]  <= bus.data;
                    REG_SX_HI:  sx_stg[9:8]  <= bus.data[1:0];
                    REG_SY_LO:  sy_stg[7:0]  <= bus.data;
                    REG_SY_HI:  sy_stg[8]    <= bus.data[0];
                    REG_STATUS: irq_en       <= bus.data[STATUS_IRQ_EN];
                    default: ;
                endcase
            end

            if (vs_pulse)
                pend <= 1'b1;
            else if (wr_go && bus.addr == REG_STATUS && bus.data[STATUS_PEND])
                pend <= 1'b0;

            irq <= pend & irq_en;
        end
    end
endmodule

// File: tb/tb_video_reg_file.sv
// tb/tb_video_reg_file.sv - table, directed and randomized checks for video_reg_file
module tb_video_reg_file;
    logic        clk_100mhz = 1'b0;
    logic        rstn_i;
    logic        vsync;
    logic [11:0] fg_color, bg_color;
    logic [9:0]  scroll_x;
    logic [8:0]  scroll_y;
    logic [5:0]  frame_count;
    logic        irq;

    video_reg_if bus ();

    video_reg_file dut (
        .clk_100mhz (clk_100mhz),
        .rstn_i     (rstn_i),
        .bus        (bus),
        .vsync      (vsync),
        .fg_color   (fg_color),
        .bg_color   (bg_color),
        .scroll_x   (scroll_x),
        .scroll_y   (scroll_y),
        .frame_count(frame_count),
        .irq        (irq)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents as integers, following the register map.
    int m_fg, m_bg, m_sx, m_sy, c_fg, c_bg, c_sx, c_sy, m_frame;
    bit m_pend, m_irq_en;

    typedef struct {
        bit         wr;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_fg = 'hFFF; m_bg = 0; m_sx = 0; m_sy = 0;
        c_fg = 'hFFF; c_bg = 0; c_sx = 0; c_sy = 0;
        m_frame = 0; m_pend = 0; m_irq_en = 0;
    endfunction

    function automatic void model_write(input int a, input int d);
        case (a)
            0: m_fg = (m_fg & 'hF00) | d;
            1: m_fg = (m_fg & 'h0FF) | ((d % 16) * 256);
            2: m_bg = (m_bg & 'hF00) | d;
            3: m_bg = (m_bg & 'h0FF) | ((d % 16) * 256);
            4: m_sx = (m_sx & 'h300) | d;
            5: m_sx = (m_sx & 'h0FF) | ((d % 4) * 256);
            6: m_sy = (m_sy & 'h100) | d;
            7: m_sy = (m_sy & 'h0FF) | ((d % 2) * 256);
            9: begin
                if (d % 2 == 1) m_pend = 0;
                m_irq_en = (d / 2) % 2;
            end
            default: ;
        endcase
    endfunction

    function automatic int model_read(input int a);
        case (a)
            0: return m_fg % 256;
            1: return m_fg / 256;
            2: return m_bg % 256;
            3: return m_bg / 256;
            4: return m_sx % 256;
            5: return m_sx / 256;
            6: return m_sy % 256;
            7: return m_sy / 256;
            8: return m_frame;
            9: return int'(m_pend) + 2 * int'(m_irq_en);
            default: return 0;
        endcase
    endfunction

    function automatic void model_vsync();
        c_fg = m_fg; c_bg = m_bg; c_sx = m_sx; c_sy = m_sy;
        m_frame = (m_frame + 1) % 64;
        m_pend = 1;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_fg"},    32'(fg_color),    32'(c_fg));
        check({tag, "_bg"},    32'(bg_color),    32'(c_bg));
        check({tag, "_sx"},    32'(scroll_x),    32'(c_sx));
        check({tag, "_sy"},    32'(scroll_y),    32'(c_sy));
        check({tag, "_frame"}, 32'(frame_count), 32'(m_frame));
        check({tag, "_irq"},   32'(irq),         32'(m_pend & m_irq_en));
    endtask

    task automatic idle_bus();
        bus.cs = 0; bus.rd = 0; bus.wr = 0; bus.addr = '0; bus.data = '0;
    endtask

    task automatic do_reset();
        rstn_i = 0;
        idle_bus();
        vsync = 1;
        repeat (3) @(posedge clk_100mhz);
        #1 rstn_i = 1;
        model_reset();
        repeat (2) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        @(posedge clk_100mhz); #1;
        bus.cs = 1; bus.addr = a; bus.data = d; bus.wr = 1;
        repeat (6) @(posedge clk_100mhz);
        #1 bus.wr = 0;
        repeat (3) @(posedge clk_100mhz);
        #1 idle_bus();
        model_write(int'(a), int'(d));
    endtask

    // Read checks the k+3 latency (4th sample after the strobe is driven) and a single pulse.
    task automatic do_read(input logic [6:0] a, output logic [7:0] d);
        int cnt, lat;
        cnt = 0; lat = 0; d = 'x;
        @(posedge clk_100mhz); #1;
        bus.cs = 1; bus.addr = a; bus.rd = 1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk_100mhz); #1;
            if (i == 9) bus.rd = 0;
            if (bus.rd_valid) begin
                cnt++;
                if (cnt == 1) begin lat = i; d = bus.rdata; end
            end
        end
        idle_bus();
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_pulses",  32'(cnt), 32'd1);
    endtask

    task automatic vsync_pulse();
        @(posedge clk_100mhz); #1 vsync = 0;
        repeat (5) @(posedge clk_100mhz);
        #1 vsync = 1;
        repeat (5) @(posedge clk_100mhz);
        #1;
        model_vsync();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int cnt;

        do_reset();
        check("rst_fg",    32'(fg_color),     32'hFFF);
        check("rst_bg",    32'(bg_color),     32'h000);
        check("rst_sx",    32'(scroll_x),     32'h0);
        check("rst_sy",    32'(scroll_y),     32'h0);
        check("rst_frame", 32'(frame_count),  32'h0);
        check("rst_irq",   32'(irq),          32'h0);
        check("rst_rdv",   32'(bus.rd_valid), 32'h0);

        // Scroll staging, read-back and exact commit timing.
        do_write(7'h04, 8'h7F);
        do_write(7'h05, 8'h02);
        do_read(7'h04, rd); check("sx_lo_rd", 32'(rd), 32'h7F);
        do_read(7'h05, rd); check("sx_hi_rd", 32'(rd), 32'h02);
        check("sx_uncommitted", 32'(scroll_x), 32'h0);
        @(posedge clk_100mhz); #1 vsync = 0;
        repeat (3) @(posedge clk_100mhz);
        #1 check("sx_pre_commit", 32'(scroll_x), 32'h0);
        @(posedge clk_100mhz);
        #1 check("sx_commit", 32'(scroll_x), 32'h27F);
        repeat (3) @(posedge clk_100mhz);
        #1 vsync = 1;
        repeat (5) @(posedge clk_100mhz);
        model_vsync();

        // Register map table.
        do_reset();
        vecs.push_back('{1'b1, 7'h00, 8'hA5, 8'h00});
        vecs.push_back('{1'b1, 7'h01, 8'hF3, 8'h00});
        vecs.push_back('{1'b1, 7'h02, 8'h5A, 8'h00});
        vecs.push_back('{1'b1, 7'h03, 8'h1C, 8'h00});
        vecs.push_back('{1'b1, 7'h04, 8'h3C, 8'h00});
        vecs.push_back('{1'b1, 7'h05, 8'hFE, 8'h00});
        vecs.push_back('{1'b1, 7'h06, 8'h81, 8'h00});
        vecs.push_back('{1'b1, 7'h07, 8'hFF, 8'h00});
        vecs.push_back('{1'b1, 7'h08, 8'h3F, 8'h00});
        vecs.push_back('{1'b1, 7'h09, 8'h02, 8'h00});
        vecs.push_back('{1'b1, 7'h0A, 8'hFF, 8'h00});
        vecs.push_back('{1'b1, 7'h7F, 8'h12, 8'h00});
        vecs.push_back('{1'b0, 7'h00, 8'h00, 8'hA5});
        vecs.push_back('{1'b0, 7'h01, 8'h00, 8'h03});
        vecs.push_back('{1'b0, 7'h02, 8'h00, 8'h5A});
        vecs.push_back('{1'b0, 7'h03, 8'h00, 8'h0C});
        vecs.push_back('{1'b0, 7'h04, 8'h00, 8'h3C});
        vecs.push_back('{1'b0, 7'h05, 8'h00, 8'h02});
        vecs.push_back('{1'b0, 7'h06, 8'h00, 8'h81});
        vecs.push_back('{1'b0, 7'h07, 8'h00, 8'h01});
        vecs.push_back('{1'b0, 7'h08, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 7'h09, 8'h00, 8'h02});
        vecs.push_back('{1'b0, 7'h0A, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 7'h7F, 8'h00, 8'h00});
        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else begin
                do_read(vecs[i].addr, rd);
                check($sformatf("tbl_rd_%0h", vecs[i].addr), 32'(rd), 32'(vecs[i].exp));
            end
        end
        vsync_pulse();
        check("tbl_fg", 32'(fg_color), 32'h3A5);
        check("tbl_bg", 32'(bg_color), 32'hC5A);
        check("tbl_sx", 32'(scroll_x), 32'h23C);
        check("tbl_sy", 32'(scroll_y), 32'h181);
        check_outputs("tbl");

        // Randomized operations against the model.
        for (int n = 0; n < 120; n++) begin
            int op, a;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 127) : $urandom_range(0, 11);
            if (op < 4) do_write(7'(a), 8'($urandom));
            else if (op < 8) begin
                do_read(7'(a), rd);
                check($sformatf("rnd_rd_%0h", a), 32'(rd), 32'(model_read(a)));
            end else begin
                vsync_pulse();
                check_outputs("rnd_vs");
            end
            check("rnd_irq", 32'(irq), 32'(m_pend & m_irq_en));
        end

        // Frame counter over a full wrap.
        do_reset();
        for (int p = 1; p <= 64; p++) begin
            vsync_pulse();
            check($sformatf("frame_%0d", p), 32'(frame_count), 32'(p % 64));
            if (p == 5) begin
                do_read(7'h08, rd);
                check("frame_rd", 32'(rd), 32'h05);
            end
        end

        // Interrupt enable, W1C, and W1C colliding with vsync start.
        do_reset();
        do_write(7'h09, 8'h02);
        check("irq_en_only", 32'(irq), 32'h0);
        vsync_pulse();
        check("irq_set", 32'(irq), 32'h1);
        do_write(7'h09, 8'h03);
        check("irq_w1c", 32'(irq), 32'h0);
        do_read(7'h09, rd); check("status_after_w1c", 32'(rd), 32'h02);
        @(posedge clk_100mhz); #1;
        bus.cs = 1; bus.addr = 7'h09; bus.data = 8'h03; bus.wr = 1; vsync = 0;
        repeat (6) @(posedge clk_100mhz);
        #1 bus.wr = 0; vsync = 1;
        repeat (4) @(posedge clk_100mhz);
        #1 idle_bus();
        model_write(9, 3);
        model_vsync();
        check("w1c_vs_irq", 32'(irq), 32'h1);
        do_read(7'h09, rd); check("w1c_vs_status", 32'(rd), 32'h03);

        // rd and wr edges together: write wins, no read pulse.
        @(posedge clk_100mhz); #1;
        bus.cs = 1; bus.addr = 7'h02; bus.data = 8'h55; bus.rd = 1; bus.wr = 1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_100mhz); #1;
            if (i == 8) begin bus.rd = 0; bus.wr = 0; end
            if (bus.rd_valid) cnt++;
        end
        idle_bus();
        model_write(2, 'h55);
        check("rdwr_no_rdv", 32'(cnt), 32'h0);
        do_read(7'h02, rd); check("rdwr_bg", 32'(rd), 32'h55);

        // Long strobe: data changes mid-hold must not cause a second write.
        @(posedge clk_100mhz); #1;
        bus.cs = 1; bus.addr = 7'h00; bus.data = 8'h33; bus.wr = 1;
        repeat (6) @(posedge clk_100mhz);
        #1 bus.data = 8'hAA;
        repeat (34) @(posedge clk_100mhz);
        #1 bus.wr = 0;
        repeat (3) @(posedge clk_100mhz);
        #1 idle_bus();
        model_write(0, 'h33);
        do_read(7'h00, rd); check("long_wr_once", 32'(rd), 32'h33);

        // Reset one cycle into a write aborts it.
        do_reset();
        @(posedge clk_100mhz); #1;
        bus.cs = 1; bus.addr = 7'h00; bus.data = 8'h12; bus.wr = 1;
        @(posedge clk_100mhz); #1 rstn_i = 0;
        @(posedge clk_100mhz); #1 idle_bus();
        repeat (2) @(posedge clk_100mhz);
        #1 rstn_i = 1;
        model_reset();
        repeat (3) @(posedge clk_100mhz);
        do_read(7'h00, rd); check("abort_fg_lo", 32'(rd), 32'hFF);
        do_read(7'h01, rd); check("abort_fg_hi", 32'(rd), 32'h0F);

        // Strobe still high at reset release produces a fresh write.
        @(posedge clk_100mhz); #1;
        bus.cs = 1; bus.addr = 7'h00; bus.data = 8'h12; bus.wr = 1;
        @(posedge clk_100mhz); #1 rstn_i = 0;
        repeat (3) @(posedge clk_100mhz);
        #1 rstn_i = 1;
        model_reset();
        model_write(0, 'h12);
        repeat (6) @(posedge clk_100mhz);
        #1 bus.wr = 0;
        repeat (3) @(posedge clk_100mhz);
        #1 idle_bus();
        do_read(7'h00, rd); check("rerun_fg_lo", 32'(rd), 32'h12);
        check("rerun_fg_committed", 32'(fg_color), 32'hFFF);
        check_outputs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_reg_file.md
# video_reg_file

Responder-side control register file for the graphics generator, clocked at clk_100mhz. It accepts the strobe-based rd/wr/addr/data register protocol driven from the pix_clk domain, the same protocol the text area uses. It holds the colour, scroll and frame-status registers, double-buffered so that display-visible values change only at vsync. The top level routes its outputs to the colour and scroll consumers in place of the fixed reg_fg_color, reg_bg_color and reg_scroll_* registers.

## Interface
- VSYNC_ACTIVE_LOW, default 1: polarity of i_vsync. Vsync start is the transition into the active level.
- FG_RESET, default 12'hFFF: reset value of foreground colour.
- BG_RESET, default 12'h000: reset value of background colour.

Ports:
- clk_100mhz  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low; clock clk_100mhz
- i_cs  in  1  block select; qualifies i_rd/i_wr edges
- i_rd  in  1  read strobe (pix_clk domain, held ≥4 clk_100mhz cycles)
- i_wr  in  1  write strobe (pix_clk domain, held ≥4 clk_100mhz cycles)
- i_addr  in  7  register address
- i_data  in  8  write data
- i_vsync  in  1  vsync from vga_core
- o_data  out  8  read data, held until next read
- o_rd_valid  out  1  one-cycle pulse when o_data updates
- o_fg_color  out  12  committed foreground colour
- o_bg_color  out  12  committed background colour
- o_scroll_x  out  10  committed horizontal scroll
- o_scroll_y  out  9  committed vertical scroll
- o_frame_count  out  6  frame counter
- o_irq  out  1  vsync interrupt, level

## Operation
- i_rd, i_wr and i_vsync each pass through a 2-flop synchronizer followed by a rising-edge detector. An access is triggered by an edge with i_cs high.
- i_addr, i_data and i_cs are sampled raw on the detect cycle. The initiator holds them stable from strobe rise for ≥3 cycles.
- Register map (unlisted bits read 0). Writes to all registers except 0x08 go to staging registers:
  - 0x00 FG[7:0]; 0x01 FG[11:8] in bits [3:0]
  - 0x02 BG[7:0]; 0x03 BG[11:8] in bits [3:0]
  - 0x04 SX[7:0]; 0x05 SX[9:8] in bits [1:0]
  - 0x06 SY[7:0]; 0x07 SY[8] in bit 0
  - 0x08 FRAME_COUNT, read-only, bits [5:0]
  - 0x09 STATUS: bit0 PEND (write-1-to-clear), bit1 IRQ_EN (RW)
  - 0x0A–0x7F: read 0, writes ignored
- Reads return staging values, not committed values.
- On vsync start (detected edge), in a single cycle:
  - all staging values copy to the o_* colour and scroll outputs;
  - o_frame_count increments, wrapping 63→0;
  - PEND sets.
- o_irq is registered as PEND & IRQ_EN.
- Scroll values are stored exactly as written; the consumer performs the modulo 640/480.
- Simultaneous events:
  - rd and wr edges in the same cycle: the write is performed and no o_rd_valid is generated.
  - STATUS W1C on the same cycle as vsync start: PEND ends at 1 (set wins).
  - Staging write on the same cycle as vsync commit: the commit uses the pre-write staging value; the new value commits at the next vsync.
- Reset values:
  - staging and committed FG = FG_RESET, BG = BG_RESET;
  - scroll 0, frame 0, PEND 0, IRQ_EN 0;
  - o_data 0, o_rd_valid 0, o_irq 0;
  - synchronizer and edge flops 0, so a strobe already high when rstn_i releases generates an edge.
- Reset asserted mid-access aborts the access. No partial register update survives.

## Timing
- Strobe first sampled high at edge k → synchronized at k+1 → edge detected at k+2.
- A write lands in staging at k+3.
- For a read, o_data and the o_rd_valid pulse occur at k+3.
- Vsync first sampled active at edge k → committed outputs, frame count and PEND update at k+3.
- o_irq follows PEND or IRQ_EN changes by 1 cycle.
- A strobe held high for any length produces exactly one access. Re-triggering requires ≥2 cycles low.

## Structure
- Package video_reg_pkg holds:
  - address localparams REG_FG_LO … REG_STATUS;
  - STATUS bit indices;
  - width constants for colour (12), scroll x (10), scroll y (9) and frame (6).
- Sub-module sync_edge: 2-flop synchronizer plus a registered rising-edge pulse, with async active-low reset. It is instantiated three times (rd, wr, vsync).

## Test plan
- Reset release: o_fg_color=12'hFFF, o_bg_color=0, scroll=0, o_frame_count=0, o_irq=0, o_rd_valid=0.
- Write 0x04←0x7F and 0x05←0x02, then read 0x04 and 0x05 → o_data 0x7F then 0x02. o_scroll_x stays 0 until the next vsync start, then reads 10'h27F 3 cycles after vsync is sampled.
- 64 vsync pulses → o_frame_count counts 1…63, then wraps to 0. Reading 0x08 after 5 pulses → 0x05.
- Write 0x09←0x02 (IRQ_EN), then pulse vsync → o_irq=1. Write 0x09←0x03 → o_irq=0. A W1C timed on the vsync-start cycle → PEND stays 1.
- Raise rd and wr together at 0x02 with data 0x55 → BG staging=0x55 and no o_rd_valid pulse. Hold i_wr high for 40 cycles → exactly one write.
- Drop rstn_i 1 cycle after i_wr rises to 0x00 with data 0x12 → FG staging remains 12'hFFF after reset release, unless i_wr is still high at release.
